// File: rtl/cpu_fetch_unit_pkg.sv
// Shared encodings for the fetch unit: PC-select codes, fetch FSM states and
// the default reset PC.
package cpu_fetch_unit_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_BRANCH = 2'b10,
    PS_JUMP   = 2'b11
  } ps_e;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fsm_e;

endpackage

// File: rtl/cpu_fetch_unit_pc_next.sv
// Combinational next-PC selection: hold, increment, relative branch or absolute
// jump. Every result wraps modulo 2^ADDR_W.
module cpu_fetch_unit_pc_next
  import cpu_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [1:0]        ps,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       pc_offset,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc_next
);

  logic signed [15:0]  offset_s;
  logic [ADDR_W-1:0]   offset_ext;

  // A size cast of a signed value sign-extends or truncates to the PC width.
  assign offset_s   = pc_offset;
  assign offset_ext = ADDR_W'(offset_s);

  always_comb begin
    pc_next = pc;
    case (ps_e'(ps))
      PS_HOLD:   pc_next = pc;
      PS_INC:    pc_next = pc + ADDR_W'(1);
      PS_BRANCH: pc_next = pc + offset_ext;
      PS_JUMP:   pc_next = jump_addr;
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns PC, IR and the execution-state bit. Fetches one
// instruction at a time over req/ack, then applies the decoder's PS/IR_L/NS.
module cpu_fetch_unit
  import cpu_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ps,
  input  logic              ir_l,
  input  logic              ns,
  input  logic [15:0]       pc_offset,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [15:0]       ir,
  output logic              state,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_valid
);

  fsm_e              fsm_q, fsm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              state_q, state_d;
  logic              req_q, req_d;
  logic              exec_valid_q, exec_valid_d;
  logic [ADDR_W-1:0] pc_next;

  cpu_fetch_unit_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .ps        (ps),
    .pc        (pc_q),
    .pc_offset (pc_offset),
    .jump_addr (jump_addr),
    .pc_next   (pc_next)
  );

  // req_q is low for the first FETCH cycle after reset, so an ack left over
  // from a cancelled request cannot load IR.
  always_comb begin
    fsm_d        = fsm_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    state_d      = state_q;
    req_d        = req_q;
    exec_valid_d = exec_valid_q;
    case (fsm_q)
      FETCH: begin
        if (req_q && imem_ack) begin
          ir_d         = imem_rdata;
          fsm_d        = EXEC;
          req_d        = 1'b0;
          exec_valid_d = 1'b1;
        end else begin
          req_d        = 1'b1;
          exec_valid_d = 1'b0;
        end
      end
      EXEC: begin
        pc_d    = pc_next;
        state_d = ns;
        if (ir_l) begin
          fsm_d        = FETCH;
          req_d        = 1'b1;
          exec_valid_d = 1'b0;
        end else begin
          req_d        = 1'b0;
          exec_valid_d = 1'b1;
        end
      end
      default: begin
        fsm_d        = FETCH;
        req_d        = 1'b0;
        exec_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= 16'h0000;
      state_q      <= 1'b0;
      req_q        <= 1'b0;
      exec_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      state_q      <= state_d;
      req_q        <= req_d;
      exec_valid_q <= exec_valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign state      = state_q;
  assign exec_valid = exec_valid_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: instruction-level vector table,
// hand-written multi-cycle/reset sequences and a randomized run against a model.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ps;
  logic        ir_l, ns;
  logic [15:0] pc_offset, jump_addr;
  logic        imem_req;
  logic [15:0] imem_addr, imem_rdata;
  logic        imem_ack;
  logic [15:0] ir;
  logic        state;
  logic [15:0] pc;
  logic        exec_valid;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: instruction-level view of the fetch unit.
  int m_pc;
  int m_ir;
  int m_state;
  bit m_exec;    // an instruction is currently executing
  bit m_armed;   // a fetch request is outstanding (false just after reset)

  cpu_fetch_unit #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps         (ps),
    .ir_l       (ir_l),
    .ns         (ns),
    .pc_offset  (pc_offset),
    .jump_addr  (jump_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ir         (ir),
    .state      (state),
    .pc         (pc),
    .exec_valid (exec_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_state = 0; m_exec = 0; m_armed = 0;
  endtask

  task automatic model_step(input logic ack, input logic [15:0] rdata, input logic [1:0] sel,
                            input logic load, input logic nst, input logic [15:0] off,
                            input logic [15:0] jaddr);
    if (m_exec) begin
      if (sel == 2'd1)      m_pc = (m_pc + 1) % 65536;
      else if (sel == 2'd2) m_pc = (m_pc + int'(off)) % 65536;
      else if (sel == 2'd3) m_pc = int'(jaddr);
      m_state = int'(nst);
      if (load) m_exec = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (ack) begin
      m_ir   = int'(rdata);
      m_exec = 1;
    end
  endtask

  task automatic check_outputs();
    chk("imem_req",   {31'd0, imem_req},   (!m_exec && m_armed) ? 1 : 0);
    chk("imem_addr",  {16'd0, imem_addr},  m_pc);
    chk("pc",         {16'd0, pc},         m_pc);
    chk("ir",         {16'd0, ir},         m_ir);
    chk("state",      {31'd0, state},      m_state);
    chk("exec_valid", {31'd0, exec_valid}, m_exec ? 1 : 0);
  endtask

  // Entered and left at the falling edge; outputs checked 1ns after driving.
  task automatic cycle(input logic rn, input logic ack, input logic [15:0] rdata,
                       input logic [1:0] sel, input logic load, input logic nst,
                       input logic [15:0] off, input logic [15:0] jaddr);
    reset_n = rn; imem_ack = ack; imem_rdata = rdata;
    ps = sel; ir_l = load; ns = nst; pc_offset = off; jump_addr = jaddr;
    if (!rn) model_reset();
    #1 check_outputs();
    @(posedge clk);
    if (rn) model_step(ack, rdata, sel, load, nst, off, jaddr);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0);
  endtask

  // One single-cycle instruction: optional wait states, ack, one EXEC cycle.
  task automatic do_instr(input logic [15:0] rdata, input logic [1:0] sel,
                          input logic [15:0] off, input logic [15:0] jaddr, input int waits);
    int guard = 0;
    while (!(m_armed && !m_exec)) begin
      idle();
      guard++;
      if (guard > 4) begin
        chk("fetch_ready_timeout", 1, 0);
        return;
      end
    end
    repeat (waits) cycle(1'b1, 1'b0, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, rdata, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, sel, 1'b1, 1'b0, off, jaddr);
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic [1:0]  sel;
    logic [15:0] off;
    logic [15:0] jaddr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h1001, 2'b01, 16'h0000, 16'h0000, 16'h0001};
    vecs[1] = '{16'h1002, 2'b01, 16'h0000, 16'h0000, 16'h0002};
    vecs[2] = '{16'h1003, 2'b11, 16'h0000, 16'h0010, 16'h0010};
    vecs[3] = '{16'h2004, 2'b10, 16'hFFFC, 16'h0000, 16'h000C};
    vecs[4] = '{16'h3005, 2'b11, 16'h0000, 16'h1234, 16'h1234};
    vecs[5] = '{16'h4006, 2'b00, 16'h7777, 16'h5555, 16'h1234};
    vecs[6] = '{16'h5007, 2'b11, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{16'h6008, 2'b01, 16'h0000, 16'h0000, 16'h0000};
    vecs[8] = '{16'h7009, 2'b10, 16'h0005, 16'h0000, 16'h0005};

    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ps = '0;
    ir_l = 1'b0; ns = 1'b0; pc_offset = '0; jump_addr = '0;
    model_reset();
    @(negedge clk);
    cycle(1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);

    // Zero-wait instruction stream with hand-computed next PCs.
    for (int i = 0; i < 9; i++) begin
      do_instr(vecs[i].rdata, vecs[i].sel, vecs[i].off, vecs[i].jaddr, 0);
      chk($sformatf("tbl_pc[%0d]", i), {16'd0, imem_addr}, {16'd0, vecs[i].exp_pc});
      chk($sformatf("tbl_ir[%0d]", i), {16'd0, ir}, {16'd0, vecs[i].rdata});
    end

    // Three wait states before the ack.
    do_instr(16'hA5A5, 2'b01, 16'h0, 16'h0, 3);
    chk("wait_ir", {16'd0, ir}, 32'h0000A5A5);

    // Multi-cycle instruction, including a spurious ack while executing.
    cycle(1'b1, 1'b1, 16'hABCD, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 2'b01, 1'b0, 1'b1, 16'h0, 16'h0);
    chk("mc_state1", {31'd0, state}, 32'd1);
    cycle(1'b1, 1'b1, 16'hDEAD, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0);
    chk("mc_ir_kept", {16'd0, ir}, 32'h0000ABCD);
    cycle(1'b1, 1'b0, 16'h0, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("mc_state0", {31'd0, state}, 32'd0);
    chk("mc_req", {31'd0, imem_req}, 32'd1);

    // Reset while waiting for an ack; stray ack held through release.
    cycle(1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_fetch_ir", {16'd0, ir}, 32'd0);
    chk("rst_fetch_pc", {16'd0, pc}, 32'd0);

    // Reset during an EXEC cycle that would jump and set state.
    do_instr(16'h1111, 2'b11, 16'h0, 16'h0040, 0);
    cycle(1'b1, 1'b1, 16'h2222, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h5555);
    idle();
    chk("rst_exec_pc", {16'd0, pc}, 32'd0);
    chk("rst_exec_state", {31'd0, state}, 32'd0);
    chk("rst_exec_ir", {16'd0, ir}, 32'd0);

    // Randomized traffic checked every cycle against the model.
    for (int n = 0; n < 400; n++) begin
      logic rn;
      rn = ($urandom_range(0, 39) != 0);
      cycle(rn, ($urandom_range(0, 2) == 0), 16'($urandom), 2'($urandom),
            ($urandom_range(0, 2) != 0), 1'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
